tx_serial_controle: RTL and testbench
=====================================

TX_SERIAL_CONTROLE -- requirements
Module: tx_serial_controle

Interface
REQ-001 The block SHALL have parameter M, default 434, giving clock cycles per serial bit period; legal values are M >= 2.
REQ-002 The block SHALL have parameter N_BITS, default 11, giving the number of shift pulses per frame (start + 7 data + parity + 2 stop); legal values are N_BITS >= 1.
REQ-003 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port partida, input, 1 bit: level-sensitive transmit request.
REQ-006 The block SHALL have port carrega, output, 1 bit: load strobe to the external N-bit shift register.
REQ-007 The block SHALL have port desloca, output, 1 bit: shift-right strobe to the shift register.
REQ-008 The block SHALL have port pronto, output, 1 bit: one-cycle frame-complete pulse.
REQ-009 The block SHALL have port db_estado, output, 4 bits: current FSM state code.

Function
REQ-010 The block SHALL implement a Moore FSM with the states INICIAL=0, PREPARACAO=1, ESPERA=2, TRANSMISSAO=3, FINAL=4, with db_estado equal to the state code; unused codes SHALL go to INICIAL on the next clock.
REQ-011 The block SHALL decode outputs from the state only: carrega=1 only in PREPARACAO, desloca=1 only in TRANSMISSAO, pronto=1 only in FINAL, and all other outputs 0.
REQ-012 INICIAL SHALL go to PREPARACAO when partida=1 and remain in INICIAL otherwise.
REQ-013 PREPARACAO SHALL last exactly one cycle, clear the tick counter and bit counter to 0, and go to ESPERA.
REQ-014 The tick counter (width ceil(log2 M)) SHALL increment every cycle in ESPERA and TRANSMISSAO, wrap from M-1 to 0, and hold in all other states; fim_tick = (tick == M-1).
REQ-015 ESPERA SHALL go to TRANSMISSAO when fim_tick=1 and remain in ESPERA otherwise.
REQ-016 TRANSMISSAO SHALL last one cycle and increment the bit counter (width ceil(log2(N_BITS+1))).
REQ-017 On leaving TRANSMISSAO, the FSM SHALL go to FINAL if the bit counter equals N_BITS-1 before the increment, and to ESPERA otherwise, so that exactly N_BITS desloca pulses occur per frame.
REQ-018 With partida sampled high at edge k, carrega SHALL be high in cycle k+1, the first desloca in cycle k+2+M, successive desloca pulses every M cycles, and pronto in the cycle after the last desloca.
REQ-019 FINAL SHALL last one cycle and go to INICIAL.
REQ-020 If partida is still high in INICIAL after FINAL, a new frame SHALL start with no extra idle cycle.
REQ-021 partida SHALL be ignored in every state except INICIAL, with no queuing and no effect on the frame in progress.
REQ-022 carrega and desloca SHALL never be high in the same cycle.

Reset
REQ-023 reset=1 SHALL force INICIAL, tick=0, bit counter=0, carrega=desloca=pronto=0 and db_estado=0 immediately, without waiting for a clock edge.
REQ-024 A reset asserted mid-frame SHALL abort the frame, and after release no desloca or pronto SHALL occur until a new partida.

Verification
REQ-025 With M=4, N_BITS=11: a partida pulse at edge 0 -> carrega in cycle 1, desloca in cycles 6,10,...,46 (11 pulses), pronto in cycle 47 only, db_estado back to 0 in cycle 48.
REQ-026 With partida held high for 3 frames -> 3 carrega pulses, each following the previous pronto by exactly one INICIAL cycle, and 33 desloca pulses in total.
REQ-027 With partida toggled in ESPERA and TRANSMISSAO mid-frame -> the desloca timing is identical to REQ-025 and exactly one pronto occurs.
REQ-028 With reset asserted between two clock edges after the 5th desloca -> outputs and db_estado are 0 at once, and no further strobes occur for 20 cycles with partida=0.
REQ-029 With M=2, N_BITS=1 (boundary case) -> carrega in cycle 1, desloca in cycle 4, pronto in cycle 5.
REQ-030 The bench SHALL assert every cycle that carrega & desloca is never 1, that pronto is never high for two consecutive cycles, and that db_estado is never greater than 4 after reset.

Source files
------------

// File: rtl/tx_serial_controle.sv
// rtl/tx_serial_controle.sv - serial transmit frame sequencer (load, timed shifts, done pulse)
// Drives an external shift register: one load, then N_BITS shift pulses spaced M clocks apart.
module tx_serial_controle #(
  parameter int M      = 434,
  parameter int N_BITS = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  output logic       carrega,
  output logic       desloca,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(M);
  localparam int BW = $clog2(N_BITS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(M - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    ESPERA      = 4'd2,
    TRANSMISSAO = 4'd3,
    FINAL       = 4'd4
  } state_t;

  state_t state, next_state;

  logic [TW-1:0] tick;
  logic [BW-1:0] bit_cnt;
  logic          fim_tick;

  assign fim_tick = (tick == TICK_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  // The tick keeps running through the shift cycle so pulses land exactly M clocks apart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        PREPARACAO: begin
          tick    <= '0;
          bit_cnt <= '0;
        end
        ESPERA: begin
          tick <= fim_tick ? '0 : tick + TW'(1);
        end
        TRANSMISSAO: begin
          tick    <= fim_tick ? '0 : tick + TW'(1);
          bit_cnt <= bit_cnt + BW'(1);
        end
        default: begin
          tick    <= tick;
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  always_comb begin
    next_state = INICIAL;
    carrega    = 1'b0;
    desloca    = 1'b0;
    pronto     = 1'b0;
    case (state)
      INICIAL: begin
        next_state = partida ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        carrega    = 1'b1;
        next_state = ESPERA;
      end
      ESPERA: begin
        next_state = fim_tick ? TRANSMISSAO : ESPERA;
      end
      TRANSMISSAO: begin
        desloca    = 1'b1;
        next_state = (bit_cnt == BIT_LAST) ? FINAL : ESPERA;
      end
      FINAL: begin
        pronto     = 1'b1;
        next_state = INICIAL;
      end
      default: begin
        next_state = INICIAL;
      end
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_tx_serial_controle.sv
// tb/tb_tx_serial_controle.sv - scoreboard bench for tx_serial_controle (M=4/N=11 and M=2/N=1)
module tb_tx_serial_controle;

  typedef struct {
    int t;
    int k;
  } ev_t;

  localparam int M0 = 4;
  localparam int N0 = 11;
  localparam int M1 = 2;
  localparam int N1 = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida0 = 1'b0;
  logic       partida1 = 1'b0;
  logic       carrega0, desloca0, pronto0;
  logic       carrega1, desloca1, pronto1;
  logic [3:0] estado0, estado1;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  ev_t  sb[2][$];
  int   free_at[2];
  logic prev_pronto[2];
  int   n_carrega0 = 0;
  int   n_desloca0 = 0;

  tx_serial_controle #(.M(M0), .N_BITS(N0)) dut0 (
    .clock(clock), .reset(reset), .partida(partida0),
    .carrega(carrega0), .desloca(desloca0), .pronto(pronto0), .db_estado(estado0)
  );

  tx_serial_controle #(.M(M1), .N_BITS(N1)) dut1 (
    .clock(clock), .reset(reset), .partida(partida1),
    .carrega(carrega1), .desloca(desloca1), .pronto(pronto1), .db_estado(estado1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  // Frame timing from the transmit request: load 1 cycle later, shifts every M from M+2, done after last shift.
  task automatic model(input int id, input logic p);
    int m, n;
    ev_t e;
    m = (id == 0) ? M0 : M1;
    n = (id == 0) ? N0 : N1;
    if (!reset && p && cyc >= free_at[id]) begin
      e.t = cyc + 1; e.k = 0; sb[id].push_back(e);
      for (int i = 0; i < n; i++) begin
        e.t = cyc + 2 + m + i * m; e.k = 1; sb[id].push_back(e);
      end
      e.t = cyc + 3 + n * m; e.k = 2; sb[id].push_back(e);
      e.t = cyc + 4 + n * m; e.k = 3; sb[id].push_back(e);
      free_at[id] = cyc + 4 + n * m;
    end
  endtask

  task automatic monitor(input int id, input logic c, input logic d, input logic p, input logic [3:0] st);
    ev_t e;
    int exp_v;
    int got_v;
    got_v = {25'd0, p, d, c, st};
    while (sb[id].size() > 0 && sb[id][0].t < cyc) begin
      e = sb[id].pop_front();
      check($sformatf("missed_event%0d_k%0d", id, e.k), 1, 0);
    end
    if (sb[id].size() > 0 && sb[id][0].t == cyc) begin
      e = sb[id].pop_front();
      case (e.k)
        0:       exp_v = {25'd0, 3'b001, 4'd1};
        1:       exp_v = {25'd0, 3'b010, 4'd3};
        2:       exp_v = {25'd0, 3'b100, 4'd4};
        default: exp_v = {25'd0, 3'b000, 4'd0};
      endcase
      check($sformatf("event%0d_k%0d", id, e.k), got_v, exp_v);
    end else if ({p, d, c} != 3'b000) begin
      check($sformatf("unexpected_strobe%0d", id), got_v, 0);
    end
    if (c && d) check($sformatf("carrega_and_desloca%0d", id), 1, 0);
    if (p && prev_pronto[id]) check($sformatf("pronto_twice%0d", id), 1, 0);
    if (!reset && st > 4'd4) check($sformatf("estado_range%0d", id), st, 4);
    prev_pronto[id] = p;
  endtask

  always @(negedge clock) begin
    monitor(0, carrega0, desloca0, pronto0, estado0);
    monitor(1, carrega1, desloca1, pronto1, estado1);
    if (carrega0) n_carrega0++;
    if (desloca0) n_desloca0++;
  end

  task automatic step(input logic p0, input logic p1);
    @(negedge clock);
    partida0 = p0;
    partida1 = p1;
    model(0, p0);
    model(1, p1);
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
      free_at[i] = 0;
      prev_pronto[i] = 1'b0;
    end
  endtask

  initial begin
    int c0;
    flush();
    repeat (3) @(negedge clock);
    check("reset_outputs0", {carrega0, desloca0, pronto0, estado0}, 0);
    check("reset_outputs1", {carrega1, desloca1, pronto1, estado1}, 0);
    @(negedge clock);
    reset = 1'b0;

    step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b0);

    n_carrega0 = 0;
    n_desloca0 = 0;
    repeat (97) step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b0);
    check("held_carrega_count", n_carrega0, 3);
    check("held_desloca_count", n_desloca0, 33);

    step(1'b1, 1'b1);
    repeat (3 + N0 * M0) step(1'($urandom_range(1)), 1'b0);
    repeat (20) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    c0 = cyc;
    while (cyc < c0 + 2 + 5 * M0) step(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs0", {carrega0, desloca0, pronto0, estado0}, 0);
    check("async_reset_outputs1", {carrega1, desloca1, pronto1, estado1}, 0);
    flush();
    @(negedge clock);
    reset = 1'b0;
    n_carrega0 = 0;
    n_desloca0 = 0;
    repeat (20) step(1'b0, 1'b0);
    check("post_reset_quiet", n_carrega0 + n_desloca0, 0);

    repeat (600) step(($urandom_range(7) == 0), ($urandom_range(3) == 0));
    repeat (70) step(1'b0, 1'b0);
    check("scoreboard_drained0", sb[0].size(), 0);
    check("scoreboard_drained1", sb[1].size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
